// File: rtl/stall_data_mem_pkg.sv
// Shared types and widths for the stall_data_mem responder.
// Holds the FSM state enum plus word and counter widths.
package stall_data_mem_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} mem_state_t;
  localparam int WORD_W = 16;
  localparam int CNT_W  = 4;
endpackage

// File: rtl/stall_data_mem_if.sv
// Request/response bundle between the memory stage (master) and the data memory (slave).
// The master holds enable/wr/addr/data_in until it samples done; stall and done flow back.
interface stall_data_mem_if;
  import stall_data_mem_pkg::*;

  logic              enable;
  logic              wr;
  logic [WORD_W-1:0] addr;
  logic [WORD_W-1:0] data_in;
  logic [WORD_W-1:0] data_out;
  logic              stall;
  logic              done;
  logic              err;

  modport master (output enable, wr, addr, data_in, input data_out, stall, done, err);
  modport slave  (input enable, wr, addr, data_in, output data_out, stall, done, err);
endinterface

// File: rtl/stall_data_mem_mem_array.sv
// 2^ADDR_BITS x 16 word store: synchronous write, registered read with read-enable.
// Latency 1 cycle for reads, no backpressure; whole array clears asynchronously on rst.
module mem_array
  import stall_data_mem_pkg::*;
#(
  parameter int ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we,
  input  logic                 re,
  input  logic [ADDR_BITS-1:0] idx,
  input  logic [WORD_W-1:0]    wdata,
  output logic [WORD_W-1:0]    rdata
);
  localparam int DEPTH = 1 << ADDR_BITS;

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (we) begin
      mem[idx] <= wdata;
    end
  end

  // Read register only moves on reads, so it holds the last read value across writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata <= '0;
    else if (re) rdata <= mem[idx];
  end
endmodule

// File: rtl/stall_data_mem.sv
// Multi-cycle data memory: issue-to-done LATENCY+1 cycles, stall held while idle-with-request or busy.
// Optional STALL_DATA_MEM_ALIGN_CHECK_EN: odd addresses complete in 1 cycle with err, no array access.
module stall_data_mem
  import stall_data_mem_pkg::*;
#(
  parameter int LATENCY   = 2,
  parameter int ADDR_BITS = 8
) (
  input logic            clk,
  input logic            rst,
  stall_data_mem_if.slave bus
);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

  mem_state_t            state;
  logic [CNT_W-1:0]      cnt;
  logic                  lat_wr;
  logic [ADDR_BITS-1:0]  lat_idx;
  logic [WORD_W-1:0]     lat_data;
  logic                  done_q;
  logic                  access;
  logic [WORD_W-1:0]     rdata;

  assign access = (state == BUSY) && (cnt == '0);

  mem_array #(.ADDR_BITS(ADDR_BITS)) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (access && lat_wr),
    .re    (access && !lat_wr),
    .idx   (lat_idx),
    .wdata (lat_data),
    .rdata (rdata)
  );

`ifdef STALL_DATA_MEM_ALIGN_CHECK_EN
  logic err_q;
  logic misaligned;
  assign misaligned = bus.addr[0];
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      lat_wr   <= 1'b0;
      lat_idx  <= '0;
      lat_data <= '0;
      done_q   <= 1'b0;
`ifdef STALL_DATA_MEM_ALIGN_CHECK_EN
      err_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef STALL_DATA_MEM_ALIGN_CHECK_EN
      err_q  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (bus.enable) begin
            lat_wr   <= bus.wr;
            lat_idx  <= bus.addr[ADDR_BITS:1];
            lat_data <= bus.data_in;
            cnt      <= CNT_INIT;
`ifdef STALL_DATA_MEM_ALIGN_CHECK_EN
            if (misaligned) begin
              state  <= DONE;
              done_q <= 1'b1;
              err_q  <= 1'b1;
            end else begin
              state <= BUSY;
            end
`else
            state <= BUSY;
`endif
          end
        end
        BUSY: begin
          // Request inputs are not looked at here; only the latched copies matter.
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state  <= DONE;
            done_q <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Gated by rst so an aborted request releases the pipeline immediately.
  assign bus.stall    = !rst && (((state == IDLE) && bus.enable) || (state == BUSY));
  assign bus.done     = done_q;
  assign bus.data_out = rdata;
`ifdef STALL_DATA_MEM_ALIGN_CHECK_EN
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_stall_data_mem.sv
// Bench for stall_data_mem: directed vector table, hand-written corner sequences,
// and randomized requests checked against a word-array reference model.
module tb_stall_data_mem;
  import stall_data_mem_pkg::*;

  localparam int LAT = 2;
  localparam int AB  = 8;
`ifdef STALL_DATA_MEM_ALIGN_CHECK_EN
  localparam bit ALIGN = 1'b1;
`else
  localparam bit ALIGN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  stall_data_mem_if bus();

  stall_data_mem #(.LATENCY(LAT), .ADDR_BITS(AB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: flat word array plus the last value read.
  logic [15:0] ref_mem [1 << AB];
  logic [15:0] ref_dout;

  typedef struct {
    string       name;
    bit          wr;
    logic [15:0] addr;
    logic [15:0] data;
    logic [15:0] exp_dout;
    bit          exp_err;
    int          exp_cyc;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < (1 << AB); i++) ref_mem[i] = 16'h0000;
    ref_dout = 16'h0000;
  endtask

  task automatic model(input bit wr, input logic [15:0] addr, input logic [15:0] data,
                       output logic [15:0] ed, output bit ee, output int ec);
    int idx;
    idx = (int'(addr) / 2) % (1 << AB);
    if (ALIGN && addr[0]) begin
      ee = 1'b1;
      ec = 1;
    end else begin
      ee = 1'b0;
      ec = LAT + 1;
      if (wr) ref_mem[idx] = data;
      else    ref_dout = ref_mem[idx];
    end
    ed = ref_dout;
  endtask

  // Issue one request and observe it cycle by cycle until done (bounded).
  task automatic run_req(input bit wr, input logic [15:0] addr, input logic [15:0] data,
                         input bit mangle, output int dcyc, output logic [63:0] smask,
                         output logic [15:0] dout, output logic e);
    @(posedge clk); #1;
    bus.enable  = 1'b1;
    bus.wr      = wr;
    bus.addr    = addr;
    bus.data_in = data;
    dcyc  = -1;
    smask = '0;
    dout  = 'x;
    e     = 'x;
    for (int c = 0; c < 40 && dcyc < 0; c++) begin
      @(negedge clk);
      if (bus.stall) smask[c] = 1'b1;
      if (bus.done) begin
        dcyc = c;
        dout = bus.data_out;
        e    = bus.err;
      end else if (mangle && c == 1) begin
        bus.enable  = 1'b0;
        bus.wr      = 1'($urandom);
        bus.addr    = 16'($urandom);
        bus.data_in = 16'($urandom);
      end
    end
    bus.enable = 1'b0;
  endtask

  task automatic apply(input string nm, input bit wr, input logic [15:0] addr,
                       input logic [15:0] data, input bit mangle, input logic [15:0] exp_dout,
                       input bit exp_err, input int exp_cyc);
    int          dcyc;
    logic [63:0] smask;
    logic [15:0] dout;
    logic        e;
    run_req(wr, addr, data, mangle, dcyc, smask, dout, e);
    chk({nm, ".done_cycle"}, 64'(dcyc), 64'(exp_cyc));
    chk({nm, ".stall_mask"}, smask, (64'd1 << exp_cyc) - 64'd1);
    chk({nm, ".data_out"}, 64'(dout), 64'(exp_dout));
    chk({nm, ".err"}, 64'(e), 64'(exp_err));
  endtask

  initial begin
    logic [15:0] ed;
    bit          ee;
    int          ec;
    logic [63:0] dmask;
    logic [63:0] smask;

    tbl[0] = '{"rd_w5_after_reset", 1'b0, 16'h000A, 16'h0000, 16'h0000, 1'b0, 3};
    tbl[1] = '{"wr_beef_0010",      1'b1, 16'h0010, 16'hBEEF, 16'h0000, 1'b0, 3};
    tbl[2] = '{"rd_0010",           1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b0, 3};
    tbl[3] = '{"wr_1234_0020",      1'b1, 16'h0020, 16'h1234, 16'hBEEF, 1'b0, 3};
    tbl[4] = '{"rd_odd_0011",       1'b0, 16'h0011, 16'h0000, 16'hBEEF, ALIGN, ALIGN ? 1 : 3};
    tbl[5] = '{"wr_00aa_0202",      1'b1, 16'h0202, 16'h00AA, 16'hBEEF, 1'b0, 3};
    tbl[6] = '{"rd_alias_0002",     1'b0, 16'h0002, 16'h0000, 16'h00AA, 1'b0, 3};
    tbl[7] = '{"rd_0020",           1'b0, 16'h0020, 16'h0000, 16'h1234, 1'b0, 3};

    rst         = 1'b1;
    bus.enable  = 1'b0;
    bus.wr      = 1'b0;
    bus.addr    = '0;
    bus.data_in = '0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset.data_out", 64'(bus.data_out), 64'h0);
    chk("reset.done", 64'(bus.done), 64'h0);
    chk("reset.stall", 64'(bus.stall), 64'h0);
    chk("reset.err", 64'(bus.err), 64'h0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      model(tbl[i].wr, tbl[i].addr, tbl[i].data, ed, ee, ec);
      apply(tbl[i].name, tbl[i].wr, tbl[i].addr, tbl[i].data, 1'b0,
            tbl[i].exp_dout, tbl[i].exp_err, tbl[i].exp_cyc);
    end

    // Enable held through DONE: one pulse per access, the next request only from IDLE.
    @(posedge clk); #1;
    bus.enable = 1'b1;
    bus.wr     = 1'b0;
    bus.addr   = 16'h0020;
    dmask = '0;
    smask = '0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.done)  dmask[c] = 1'b1;
      if (bus.stall) smask[c] = 1'b1;
      if (c == 7) bus.enable = 1'b0;
    end
    chk("held.done_mask", dmask, 64'h88);
    chk("held.stall_mask", smask, 64'h77);
    chk("held.data_out", 64'(bus.data_out), 64'h1234);
    model(1'b0, 16'h0020, 16'h0000, ed, ee, ec);
    model(1'b0, 16'h0020, 16'h0000, ed, ee, ec);

    for (int i = 0; i < 150; i++) begin
      bit          wr;
      bit          mg;
      logic [15:0] a;
      logic [15:0] d;
      wr = 1'($urandom);
      mg = ($urandom_range(0, 3) == 0);
      a  = 16'($urandom);
      d  = 16'($urandom);
      if ($urandom_range(0, 1) == 0) a[15:5] = '0;
      model(wr, a, d, ed, ee, ec);
      apply($sformatf("rand%0d", i), wr, a, d, mg, ed, ee, ec);
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    // Reset during BUSY of a write: abort, discard the write, drop stall at once.
    @(posedge clk); #1;
    bus.enable  = 1'b1;
    bus.wr      = 1'b1;
    bus.addr    = 16'h0040;
    bus.data_in = 16'h5555;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst.stall", 64'(bus.stall), 64'h0);
    chk("midrst.done", 64'(bus.done), 64'h0);
    chk("midrst.data_out", 64'(bus.data_out), 64'h0);
    @(negedge clk);
    bus.enable = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    apply("rd_0040_after_rst", 1'b0, 16'h0040, 16'h0000, 1'b0, 16'h0000, 1'b0, 3);
    apply("rd_w5_after_rst", 1'b0, 16'h000A, 16'h0000, 1'b0, 16'h0000, 1'b0, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
